// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/response bundle between the execute stage and the
// iterative multiply/divide unit.
//   start, funct, a, b : request from the datapath (master drives)
//   busy, done, dz, err: handshake/status back from the unit (slave drives)
//   hi, lo             : architectural HI/LO registers, read by mfhi/mflo
interface mips_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dz;
    logic             err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, funct, a, b,
        input  busy, done, dz, err, hi, lo
    );

    modport slave (
        input  start, funct, a, b,
        output busy, done, dz, err, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative radix-2 multiply/divide unit owning HI/LO.
// Handles mult, multu, div, divu (WIDTH+1 edges after the start edge)
// and mthi/mtlo (single edge, no busy/done).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : mips_muldiv_if.slave
//           start/funct/a/b in; busy/done/dz/err/hi/lo out
module mips_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mips_muldiv_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             op_div;
    logic             neg_lo;   // product sign (mult) / quotient sign (div)
    logic             neg_hi;   // remainder sign (div)
    logic             b_zero;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;   // product upper half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier shifting out / quotient shifting in

    // Request decode
    logic             is_mul, is_div, is_signed;
    logic [WIDTH-1:0] a_abs, b_abs;

    always_comb begin
        is_mul    = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
        is_div    = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
        is_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
        a_abs     = (is_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
        b_abs     = (is_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    end

    // One radix-2 step of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, opnd};
        // Remainder stays below the divisor, so the low WIDTH bits suffice.
        div_diff  = div_trial[WIDTH-1:0] - opnd;
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_lo ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix   = neg_lo ? (~acc_lo + WIDTH'(1)) : acc_lo;
        rem_fix   = neg_hi ? (~acc_hi + WIDTH'(1)) : acc_hi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            b_zero   <= 1'b0;
            a_orig   <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
            bus.err  <= 1'b0;
            bus.hi   <= '0;
            bus.lo   <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.dz   <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (is_mul || is_div) begin
                            state    <= S_RUN;
                            bus.busy <= 1'b1;
                            count    <= '0;
                            op_div   <= is_div;
                            neg_lo   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_hi   <= is_signed && bus.a[WIDTH-1];
                            b_zero   <= (bus.b == '0);
                            a_orig   <= bus.a;
                            acc_hi   <= '0;
                            if (is_mul) begin
                                opnd   <= a_abs;
                                acc_lo <= b_abs;
                            end else begin
                                opnd   <= b_abs;
                                acc_lo <= a_abs;
                            end
                        end else if (bus.funct == F_MTHI) begin
                            bus.hi <= bus.a;
                        end else if (bus.funct == F_MTLO) begin
                            bus.lo <= bus.a;
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (op_div) begin
                        acc_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (op_div) begin
                        if (b_zero) begin
                            bus.lo <= '1;
                            bus.hi <= a_orig;
                            bus.dz <= 1'b1;
                        end else begin
                            bus.lo <= quo_fix;
                            bus.hi <= rem_fix;
                        end
                    end else begin
                        {bus.hi, bus.lo} <= prod_fix;
                    end
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.funct = f;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done();
        while (!bus.done && cyc < 100) tick();
    endtask

    initial begin
        tbl[0]  = '{"multu_max",   F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[1]  = '{"mult_neg3x7", F_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[2]  = '{"mult_minsq",  F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{"mult_m1m1",   F_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        tbl[4]  = '{"multu_2p32",  F_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[5]  = '{"mult_zero",   F_MULT,  32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[6]  = '{"div_neg7_2",  F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[7]  = '{"div_7_neg2",  F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[8]  = '{"divu_100_7",  F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        tbl[9]  = '{"div_ovf",     F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[10] = '{"divu_max_1",  F_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        tbl[11] = '{"div_neg_dz",  F_DIV,   32'hFFFF_FB2E, 32'h0000_0000, 32'hFFFF_FB2E, 32'hFFFF_FFFF, 1'b1};
        tbl[12] = '{"divu_dz",     F_DIVU,  32'd1234,      32'h0000_0000, 32'd1234,      32'hFFFF_FFFF, 1'b1};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            start_op(tbl[i].funct, tbl[i].a, tbl[i].b);
            chk({tbl[i].name, "_busy_run"}, {63'd0, bus.busy}, 64'd1);
            wait_done();
            chk({tbl[i].name, "_latency"}, 64'(cyc), 64'd33);
            chk({tbl[i].name, "_hi"}, {32'd0, bus.hi}, {32'd0, tbl[i].hi});
            chk({tbl[i].name, "_lo"}, {32'd0, bus.lo}, {32'd0, tbl[i].lo});
            chk({tbl[i].name, "_dz"}, {63'd0, bus.dz}, {63'd0, tbl[i].dz});
            chk({tbl[i].name, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
            tick();
            chk({tbl[i].name, "_done_pulse"}, {62'd0, bus.done, bus.dz}, 64'd0);
        end

        // mthi / mtlo: single edge, other register untouched
        start_op(F_MTHI, 32'd5, 32'd0);
        chk("mthi_hi", {32'd0, bus.hi}, 64'd5);
        chk("mthi_lo", {32'd0, bus.lo}, {32'd0, tbl[12].lo});
        chk("mthi_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        start_op(F_MTLO, 32'd9, 32'd0);
        chk("mtlo_hi", {32'd0, bus.hi}, 64'd5);
        chk("mtlo_lo", {32'd0, bus.lo}, 64'd9);

        // Unsupported funct
        start_op(6'h20, 32'hDEAD_BEEF, 32'h1);
        chk("err_pulse", {62'd0, bus.err, bus.busy}, 64'd2);
        chk("err_hilo", {bus.hi, bus.lo}, {32'd5, 32'd9});
        tick();
        chk("err_clear", {63'd0, bus.err}, 64'd0);

        // Start during RUN is ignored; hi/lo hold during RUN
        start_op(F_MULTU, 32'd6, 32'd7);
        repeat (5) tick();
        bus.start = 1'b1;
        bus.funct = F_DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        chk("busy_start_err", {63'd0, bus.err}, 64'd0);
        chk("busy_start_busy", {63'd0, bus.busy}, 64'd1);
        chk("run_hilo_hold", {bus.hi, bus.lo}, {32'd5, 32'd9});
        wait_done();
        chk("busy_start_latency", 64'(cyc), 64'd33);
        chk("busy_start_result", {bus.hi, bus.lo}, 64'd42);
        chk("busy_start_dz", {63'd0, bus.dz}, 64'd0);

        // Back-to-back: start in the done cycle
        start_op(F_DIVU, 32'd100, 32'd7);
        wait_done();
        chk("b2b_first", {bus.hi, bus.lo}, {32'd2, 32'd14});
        start_op(F_MULT, 32'd2, 32'hFFFF_FFFC);
        chk("b2b_accept", {63'd0, bus.busy}, 64'd1);
        wait_done();
        chk("b2b_latency", 64'(cyc), 64'd33);
        chk("b2b_second", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();

        // Reset mid-RUN discards the operation
        start_op(F_MULT, 32'h1234_5678, 32'h0000_0100);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_idle", {62'd0, bus.busy, bus.done}, 64'd0);
        start_op(F_MULT, 32'd3, 32'd5);
        wait_done();
        chk("post_rst_latency", 64'(cyc), 64'd33);
        chk("post_rst_result", {bus.hi, bus.lo}, 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
